// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters, with one registered,
// tagged response slot. Defining ALU_ARB_PERF_EN adds accept/stall performance counters.
module alu_share_arbiter #(
  parameter int                DATA_W  = 64,
  parameter int                CTL_W   = 4,
  parameter logic [CTL_W-1:0]  NOP_CTL = 4'b1111
) (
  input  logic              clk,
  input  logic              reset,
  // Requester 0: EX-stage operand path
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [CTL_W-1:0]  req0_ctl,
  input  logic [DATA_W-1:0] req0_op1,
  input  logic [DATA_W-1:0] req0_op2,
  // Requester 1: branch/address helper path
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [CTL_W-1:0]  req1_ctl,
  input  logic [DATA_W-1:0] req1_op1,
  input  logic [DATA_W-1:0] req1_op2,
  // Shared ALU
  output logic [CTL_W-1:0]  alu_ctl,
  output logic [DATA_W-1:0] alu_op1,
  output logic [DATA_W-1:0] alu_op2,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  // Response slot
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero
`ifdef ALU_ARB_PERF_EN
  ,
  output logic [31:0]       perf_ops0,
  output logic [31:0]       perf_ops1,
  output logic [31:0]       perf_stall
`endif
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both high.
  // Producers hold valid and fields until ready; ready is combinational from valid and slot state.

  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
  logic              rsp_zero_q, rsp_zero_d;
  logic              last_grant_q, last_grant_d;

  logic slot_free;
  logic any_valid;
  logic grant;
  logic accept;

  always_comb begin
    slot_free = !rsp_valid_q | rsp_ready;
    any_valid = req0_valid | req1_valid;
    // Contention alternates against the previous winner; a lone requester simply wins.
    if (req0_valid & req1_valid) begin
      grant = !last_grant_q;
    end else begin
      grant = req1_valid;
    end
    // Reset gates accept so no ready escapes while reset is held.
    accept     = slot_free & any_valid & !reset;
    req0_ready = accept & req0_valid & !grant;
    req1_ready = accept & req1_valid & grant;
  end

  always_comb begin
    alu_ctl = NOP_CTL;
    alu_op1 = '0;
    alu_op2 = '0;
    if (req0_ready) begin
      alu_ctl = req0_ctl;
      alu_op1 = req0_op1;
      alu_op2 = req0_op2;
    end else if (req1_ready) begin
      alu_ctl = req1_ctl;
      alu_op1 = req1_op1;
      alu_op2 = req1_op2;
    end
  end

  always_comb begin
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    last_grant_d = last_grant_q;
    if (accept) begin
      rsp_valid_d  = 1'b1;
      rsp_id_d     = grant;
      rsp_result_d = alu_result;
      rsp_zero_d   = alu_zero;
      last_grant_d = grant;
    end else if (rsp_ready) begin
      rsp_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;

`ifdef ALU_ARB_PERF_EN
  logic [31:0] perf_ops0_q, perf_ops0_d;
  logic [31:0] perf_ops1_q, perf_ops1_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  // Counters wrap naturally through 32-bit addition.
  always_comb begin
    perf_ops0_d  = perf_ops0_q + 32'(req0_ready);
    perf_ops1_d  = perf_ops1_q + 32'(req1_ready);
    perf_stall_d = perf_stall_q + 32'(any_valid & !(req0_ready | req1_ready));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_ops0_q  <= '0;
      perf_ops1_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_ops0_q  <= perf_ops0_d;
      perf_ops1_q  <= perf_ops1_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_ops0  = perf_ops0_q;
  assign perf_ops1  = perf_ops1_q;
  assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a small behavioural ALU on the shared port.
// Build with ALU_ARB_PERF_EN to include the performance-counter scenario.
module tb_alu_share_arbiter;

  localparam int DATA_W = 64;
  localparam int CTL_W  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              req0_valid, req0_ready;
  logic [CTL_W-1:0]  req0_ctl;
  logic [DATA_W-1:0] req0_op1, req0_op2;
  logic              req1_valid, req1_ready;
  logic [CTL_W-1:0]  req1_ctl;
  logic [DATA_W-1:0] req1_op1, req1_op2;
  logic [CTL_W-1:0]  alu_ctl;
  logic [DATA_W-1:0] alu_op1, alu_op2, alu_result;
  logic              alu_zero;
  logic              rsp_valid, rsp_ready, rsp_id, rsp_zero;
  logic [DATA_W-1:0] rsp_result;
`ifdef ALU_ARB_PERF_EN
  logic [31:0]       perf_ops0, perf_ops1, perf_stall;
`endif

  int total = 0;
  int bad   = 0;
  logic [DATA_W:0] exp_q[$];

  always #5 clk = ~clk;

  alu_share_arbiter dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ctl(req0_ctl),
    .req0_op1(req0_op1), .req0_op2(req0_op2),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ctl(req1_ctl),
    .req1_op1(req1_op1), .req1_op2(req1_op2),
    .alu_ctl(alu_ctl), .alu_op1(alu_op1), .alu_op2(alu_op2),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero)
`ifdef ALU_ARB_PERF_EN
    ,
    .perf_ops0(perf_ops0), .perf_ops1(perf_ops1), .perf_stall(perf_stall)
`endif
  );

  // Behavioural ALU: undefined ctl codes return 0.
  always_comb begin
    case (alu_ctl)
      4'b0010: alu_result = alu_op1 + alu_op2;
      4'b0110: alu_result = alu_op1 - alu_op2;
      4'b0000: alu_result = alu_op1 & alu_op2;
      4'b0001: alu_result = alu_op1 | alu_op2;
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == '0);
  end

  task automatic idle_inputs();
    req0_valid = 1'b0; req0_ctl = '0; req0_op1 = '0; req0_op2 = '0;
    req1_valid = 1'b0; req1_ctl = '0; req1_op1 = '0; req1_op2 = '0;
    rsp_ready  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    req0_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    total++; if (rsp_id !== 1'b0) begin bad++; $display("FAIL reset_rsp_id got=%b exp=0", rsp_id); end
    total++; if (rsp_result !== 64'h0) begin bad++; $display("FAIL reset_rsp_result got=%h exp=0", rsp_result); end
    total++; if (rsp_zero !== 1'b0) begin bad++; $display("FAIL reset_rsp_zero got=%b exp=0", rsp_zero); end
    total++; if (req0_ready !== 1'b0) begin bad++; $display("FAIL reset_no_ready got=%b exp=0", req0_ready); end
    req0_valid = 1'b0;
    reset = 1'b0;
  endtask

  // T1: single add from requester 0, then drain with held fields.
  task automatic test_single_add();
    @(negedge clk);
    req0_valid = 1'b1; req0_ctl = 4'b0010; req0_op1 = 64'd5; req0_op2 = 64'd3;
    rsp_ready = 1'b1;
    #1;
    total++; if (req0_ready !== 1'b1) begin bad++; $display("FAIL t1_req0_ready got=%b exp=1", req0_ready); end
    total++; if (req1_ready !== 1'b0) begin bad++; $display("FAIL t1_req1_ready got=%b exp=0", req1_ready); end
    total++; if (alu_ctl !== 4'b0010) begin bad++; $display("FAIL t1_alu_ctl got=%b exp=0010", alu_ctl); end
    @(posedge clk); #1;
    total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL t1_rsp_valid got=%b exp=1", rsp_valid); end
    total++; if (rsp_id !== 1'b0) begin bad++; $display("FAIL t1_rsp_id got=%b exp=0", rsp_id); end
    total++; if (rsp_result !== 64'd8) begin bad++; $display("FAIL t1_rsp_result got=%h exp=8", rsp_result); end
    total++; if (rsp_zero !== 1'b0) begin bad++; $display("FAIL t1_rsp_zero got=%b exp=0", rsp_zero); end
    @(negedge clk);
    req0_valid = 1'b0;
    @(posedge clk); #1;
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL t1_drain_valid got=%b exp=0", rsp_valid); end
    total++; if (rsp_result !== 64'd8) begin bad++; $display("FAIL t1_drain_hold got=%h exp=8", rsp_result); end
  endtask

  // T2: both requesters every cycle; last winner was 0, so grants go 1,0,1,0.
  task automatic test_back_to_back();
    logic [DATA_W:0] exp;
    logic            exp_gnt;
    @(negedge clk);
    req0_valid = 1'b1; req0_ctl = 4'b0110; req0_op1 = 64'd7;    req0_op2 = 64'd7;
    req1_valid = 1'b1; req1_ctl = 4'b0001; req1_op1 = 64'hF0;   req1_op2 = 64'h0F;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_gnt = (i % 2 == 0);
      #1;
      total++; if (req1_ready !== exp_gnt || req0_ready !== !exp_gnt) begin
        bad++; $display("FAIL t2_grant[%0d] got=r0:%b r1:%b exp_grant=%b", i, req0_ready, req1_ready, exp_gnt);
      end
      exp_q.push_back(exp_gnt ? {1'b1, 64'hFF} : {1'b0, 64'h0});
      @(posedge clk); #1;
      exp = exp_q.pop_front();
      total++; if (rsp_valid !== 1'b1 || {rsp_id, rsp_result} !== exp) begin
        bad++; $display("FAIL t2_rsp[%0d] got=v%b id%b %h exp=id%b %h", i, rsp_valid, rsp_id, rsp_result, exp[DATA_W], exp[DATA_W-1:0]);
      end
      total++; if (rsp_zero !== !exp_gnt) begin bad++; $display("FAIL t2_zero[%0d] got=%b exp=%b", i, rsp_zero, !exp_gnt); end
      @(negedge clk);
    end
  endtask

  // T3: hold rsp_ready low with both valid; slot must freeze. Last winner was 0.
  task automatic test_backpressure();
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        bad++; $display("FAIL t3_ready[%0d] got=r0:%b r1:%b exp=0", i, req0_ready, req1_ready);
      end
      total++; if (alu_ctl !== 4'b1111) begin bad++; $display("FAIL t3_alu_nop[%0d] got=%b exp=1111", i, alu_ctl); end
      @(posedge clk); #1;
      total++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_result !== 64'h0 || rsp_zero !== 1'b1) begin
        bad++; $display("FAIL t3_hold[%0d] got=v%b id%b %h z%b exp=v1 id0 0 z1", i, rsp_valid, rsp_id, rsp_result, rsp_zero);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    total++; if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
      bad++; $display("FAIL t3_release got=r0:%b r1:%b exp=r0:0 r1:1", req0_ready, req1_ready);
    end
    @(posedge clk); #1;
    total++; if (rsp_id !== 1'b1 || rsp_result !== 64'hFF) begin
      bad++; $display("FAIL t3_release_rsp got=id%b %h exp=id1 ff", rsp_id, rsp_result);
    end
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk);
  endtask

  // T4: AND on requester 1, then idle ALU port.
  task automatic test_and_idle();
    @(negedge clk);
    req1_valid = 1'b1; req1_ctl = 4'b0000;
    req1_op1 = 64'hFFFF0000FFFF0000; req1_op2 = 64'h00FF00FF00FF00FF;
    rsp_ready = 1'b1;
    #1;
    total++; if (req1_ready !== 1'b1) begin bad++; $display("FAIL t4_req1_ready got=%b exp=1", req1_ready); end
    @(posedge clk); #1;
    total++; if (rsp_id !== 1'b1 || rsp_result !== 64'h00FF000000FF0000 || rsp_zero !== 1'b0) begin
      bad++; $display("FAIL t4_rsp got=id%b %h z%b exp=id1 00ff000000ff0000 z0", rsp_id, rsp_result, rsp_zero);
    end
    @(negedge clk);
    req1_valid = 1'b0;
    #1;
    total++; if (alu_ctl !== 4'b1111 || alu_op1 !== 64'h0 || alu_op2 !== 64'h0) begin
      bad++; $display("FAIL t4_idle_alu got=%b %h %h exp=1111 0 0", alu_ctl, alu_op1, alu_op2);
    end
    @(posedge clk);
  endtask

  // T5: async reset with a pending response; requester 0 wins first afterwards.
  task automatic test_reset_mid();
    @(negedge clk);
    req0_valid = 1'b1; req0_ctl = 4'b0010; req0_op1 = 64'd1; req0_op2 = 64'd1;
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL t5_pending got=%b exp=1", rsp_valid); end
    #1;
    reset = 1'b1;
    #1;
    total++; if (rsp_valid !== 1'b0 || rsp_result !== 64'h0) begin
      bad++; $display("FAIL t5_async_clear got=v%b %h exp=v0 0", rsp_valid, rsp_result);
    end
    req0_valid = 1'b1; req0_op1 = 64'd2; req0_op2 = 64'd2;
    req1_valid = 1'b1; req1_ctl = 4'b0001; req1_op1 = 64'h10; req1_op2 = 64'h01;
    rsp_ready = 1'b1;
    #1;
    total++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      bad++; $display("FAIL t5_ready_in_reset got=r0:%b r1:%b exp=0", req0_ready, req1_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      bad++; $display("FAIL t5_first_grant got=r0:%b r1:%b exp=r0:1 r1:0", req0_ready, req1_ready);
    end
    @(posedge clk); #1;
    total++; if (rsp_id !== 1'b0 || rsp_result !== 64'd4) begin
      bad++; $display("FAIL t5_rsp got=id%b %h exp=id0 4", rsp_id, rsp_result);
    end
    @(negedge clk);
    idle_inputs();
    @(posedge clk);
  endtask

`ifdef ALU_ARB_PERF_EN
  // T6: 10 accepts for 0, 6 for 1, then 3 backpressured cycles.
  task automatic test_perf();
    @(negedge clk);
    reset = 1'b1;
    #1;
    total++; if (perf_ops0 !== 32'd0 || perf_stall !== 32'd0) begin
      bad++; $display("FAIL t6_reset got=%0d %0d exp=0 0", perf_ops0, perf_stall);
    end
    @(negedge clk);
    reset = 1'b0;
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_ctl = 4'b0010; req0_op1 = 64'd1; req0_op2 = 64'd1;
    repeat (10) @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_ctl = 4'b0001; req1_op1 = 64'd1; req1_op2 = 64'd2;
    repeat (6) @(negedge clk);
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    req1_valid = 1'b0;
    @(negedge clk);
    total++; if (perf_ops0 !== 32'd10) begin bad++; $display("FAIL t6_ops0 got=%0d exp=10", perf_ops0); end
    total++; if (perf_ops1 !== 32'd6) begin bad++; $display("FAIL t6_ops1 got=%0d exp=6", perf_ops1); end
    total++; if (perf_stall !== 32'd3) begin bad++; $display("FAIL t6_stall got=%0d exp=3", perf_stall); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_add();
    test_back_to_back();
    test_backpressure();
    test_and_idle();
    test_reset_mid();
`ifdef ALU_ARB_PERF_EN
    test_perf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
